divu_share_arb: RTL and testbench
=================================

DIVU_SHARE_ARB -- requirements
Module: divu_share_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, the maximum number of CE cycles spent in WAIT before forced completion.
REQ-002 SHALL have parameter NREQ, default 2, the number of requester ports (fixed at 2 in this revision).
REQ-003 SHALL have port CLK  in  1  single clock; all state on its rising edge.
REQ-004 SHALL have port RST  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port CE  in  1  clock enable; all state advances only when CE=1.
REQ-006 SHALL have port REQ  in  2  per-port divide request level; held until ACK.
REQ-007 SHALL have port MODE64  in  2  per-port 1=64/32 divide, 0=32/32 divide.
REQ-008 SHALL have ports DVSR_P0/DVSR_P1  in  32 each  divisor operands.
REQ-009 SHALL have ports DVDNTH_P0/DVDNTH_P1  in  32 each  dividend high words; ignored when MODE64=0.
REQ-010 SHALL have ports DVDNTL_P0/DVDNTL_P1  in  32 each  dividend low words.
REQ-011 SHALL have port ACK  out  2  one-CE-cycle completion pulse to the owning port.
REQ-012 SHALL have ports Q, R  out  32 each  quotient and remainder, valid while ACK is nonzero.
REQ-013 SHALL have port OVF  out  1  overflow or timeout flag, valid while ACK is nonzero.
REQ-014 SHALL have port BUSY  out  2  per-port request pending and not yet acknowledged.
REQ-015 SHALL have engine ports DIV_START (out, 1-cycle pulse), DIV_64 (out), and DIV_DVSR/DIV_DVDNTH/DIV_DVDNTL (out, 32 each).
REQ-016 SHALL have engine ports DIV_DONE (in, pulse), DIV_Q/DIV_R (in, 32 each) and DIV_OVF (in).

Function
REQ-017 SHALL implement an FSM with states IDLE, LAUNCH, WAIT and RESP.
REQ-018 IDLE: with any REQ bit set, SHALL grant one port, latch its operands and MODE64 into engine registers, record OWNER, and go to LAUNCH.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests, grant the port not granted last; LAST resets to port 1, so port 0 wins the first tie.
REQ-020 LAUNCH: SHALL assert DIV_START for exactly one CE cycle, clear the timeout counter, and go to WAIT.
REQ-021 WAIT: on DIV_DONE, SHALL capture DIV_Q/DIV_R/DIV_OVF and go to RESP.
REQ-022 WAIT: if the counter reaches TIMEOUT first, SHALL go to RESP with Q=0, R=0 and OVF=1.
REQ-023 DIV_DONE SHALL be ignored in IDLE, LAUNCH and RESP.
REQ-024 RESP: SHALL pulse ACK[OWNER] for one CE cycle with Q/R/OVF valid, update LAST=OWNER, and return to IDLE.
REQ-025 Minimum latency SHALL be grant cycle + LAUNCH + n engine cycles + RESP.
REQ-026 Back-to-back operation: a new grant SHALL occur no earlier than the CE cycle after RESP.
REQ-027 If REQ[OWNER] drops after grant, the operation SHALL complete and ACK SHALL still pulse; the requester ignores it.
REQ-028 REQ dropped before grant SHALL be a withdrawal, with no ACK.
REQ-029 BUSY[i] SHALL equal REQ[i] AND NOT ACK[i].
REQ-030 Q/R/OVF SHALL hold their last values outside ACK.
REQ-031 Engine operand outputs SHALL be stable from LAUNCH through RESP.
REQ-032 When MODE64=0, the arbiter SHALL drive DIV_DVDNTH with the sign-extension of DVDNTL.

Reset
REQ-033 RST=1 SHALL asynchronously force: state IDLE, OWNER=0, LAST=1, counter=0, ACK=0, DIV_START=0, Q=R=0, OVF=0, and engine operand registers to 0.
REQ-034 Reset mid-operation SHALL abandon the divide with no ACK; the engine is reset by the same RST.

Configuration
REQ-035 With macro DIVU_ARB_FIXED_PRIO_EN defined, port 0 SHALL always win ties and LAST SHALL be unused.
REQ-036 Without DIVU_ARB_FIXED_PRIO_EN, round-robin per REQ-019 SHALL apply.

Structure
REQ-037 The package SHALL hold the FSM state enum (DA_IDLE, DA_LAUNCH, DA_WAIT, DA_RESP), an operand struct {MODE64, DVSR, DVDNTH, DVDNTL} and the default TIMEOUT constant.
REQ-038 One sub-module, divu_share_rr, SHALL contain the 2-way round-robin/fixed-priority grant logic; all other logic is inline.

Verification
REQ-039 Port 0 alone, MODE64=0, DVSR=7, DVDNTL=100, engine DONE after 39 cycles -> DIV_START pulses once; ACK=01; Q=14, R=2, OVF=0.
REQ-040 Both ports request in the same cycle after reset -> port 0 is served first and port 1 second; BUSY[1] stays high until its ACK; with DIVU_ARB_FIXED_PRIO_EN and port 0 re-requesting, port 0 is served again.
REQ-041 Engine never asserts DONE, TIMEOUT=40 -> ACK after 40 WAIT cycles with Q=0, R=0, OVF=1.
REQ-042 Port 1, MODE64=1, DVDNTH=1, DVDNTL=0, DVSR=2, engine returns Q=0x80000000, R=0, OVF=0 -> ACK=10 with matching outputs; DIV_DVDNTH=1 throughout WAIT.
REQ-043 RST asserted in WAIT, then a late DONE -> no ACK; all outputs at reset values; next request is granted normally.
REQ-044 DONE asserted in LAUNCH; CE low for 5 cycles in WAIT -> DONE ignored; counter frozen while CE=0; state unchanged.

Source files
------------

// File: rtl/divu_share_arb_pkg.sv
// divu_share_arb_pkg: shared types and constants for the shared-divider arbiter.
// Optional feature macro used by the importing files: DIVU_ARB_FIXED_PRIO_EN.
package divu_share_arb_pkg;

    // Default number of CE cycles allowed in WAIT before forced completion.
    localparam int unsigned DA_TIMEOUT_DEFAULT = 40;

    typedef enum logic [1:0] {
        DA_IDLE   = 2'd0,
        DA_LAUNCH = 2'd1,
        DA_WAIT   = 2'd2,
        DA_RESP   = 2'd3
    } da_state_e;

    typedef struct packed {
        logic        mode64;
        logic [31:0] dvsr;
        logic [31:0] dvdnth;
        logic [31:0] dvdntl;
    } da_operand_t;

    // High dividend word seen by the engine; a 32/32 divide sign-extends the low word.
    function automatic logic [31:0] da_high_word(input logic        mode64,
                                                 input logic [31:0] hi,
                                                 input logic [31:0] lo);
        return mode64 ? hi : {32{lo[31]}};
    endfunction

endpackage

// File: rtl/divu_share_rr.sv
// divu_share_rr: 2-way grant selection for the shared divider.
// With DIVU_ARB_FIXED_PRIO_EN defined port 0 always wins a tie and 'last' is absent;
// otherwise a tie goes to the port that was not served last.
module divu_share_rr (
    input  logic [1:0] req,
`ifndef DIVU_ARB_FIXED_PRIO_EN
    input  logic       last,
`endif
    output logic       gnt_valid,
    output logic       gnt
);

    // Choose the winning port index among the active requests.
    always_comb begin
        gnt_valid = |req;
        gnt       = 1'b0;
        if (req == 2'b10) begin
            gnt = 1'b1;
        end
`ifndef DIVU_ARB_FIXED_PRIO_EN
        else if (req == 2'b11) begin
            gnt = ~last;
        end
`endif
    end

endmodule

// File: rtl/divu_share_arb.sv
// divu_share_arb: arbitrates two requesters onto one external divide engine.
// Optional feature: DIVU_ARB_FIXED_PRIO_EN selects fixed priority (port 0) instead of
// round-robin tie-breaking.
module divu_share_arb
    import divu_share_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DA_TIMEOUT_DEFAULT,
    parameter int unsigned NREQ    = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CE,
    input  logic [NREQ-1:0] REQ,
    input  logic [NREQ-1:0] MODE64,
    input  logic [31:0]     DVSR_P0,
    input  logic [31:0]     DVSR_P1,
    input  logic [31:0]     DVDNTH_P0,
    input  logic [31:0]     DVDNTH_P1,
    input  logic [31:0]     DVDNTL_P0,
    input  logic [31:0]     DVDNTL_P1,
    output logic [NREQ-1:0] ACK,
    output logic [31:0]     Q,
    output logic [31:0]     R,
    output logic            OVF,
    output logic [NREQ-1:0] BUSY,
    output logic            DIV_START,
    output logic            DIV_64,
    output logic [31:0]     DIV_DVSR,
    output logic [31:0]     DIV_DVDNTH,
    output logic [31:0]     DIV_DVDNTL,
    input  logic            DIV_DONE,
    input  logic [31:0]     DIV_Q,
    input  logic [31:0]     DIV_R,
    input  logic            DIV_OVF
);

    // Counter holds 0..TIMEOUT-1; reaching TIMEOUT-1 in WAIT ends the 40th cycle.
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    da_state_e   state;
    logic        owner;
    logic [CW-1:0] cnt;
    logic [31:0] q_r;
    logic [31:0] r_r;
    logic        ovf_r;
    da_operand_t op_q;
    da_operand_t op_sel;
    logic        gnt_valid;
    logic        gnt;

`ifndef DIVU_ARB_FIXED_PRIO_EN
    logic        last;

    // Remember the most recently served port for the next tie-break.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last <= 1'b1;
        end else if (CE && state == DA_RESP) begin
            last <= owner;
        end
    end
`endif

    divu_share_rr u_rr (
        .req       (REQ[1:0]),
`ifndef DIVU_ARB_FIXED_PRIO_EN
        .last      (last),
`endif
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    // Operands of the port that would be granted this cycle.
    always_comb begin
        op_sel.mode64 = MODE64[gnt];
        op_sel.dvsr   = gnt ? DVSR_P1 : DVSR_P0;
        op_sel.dvdntl = gnt ? DVDNTL_P1 : DVDNTL_P0;
        op_sel.dvdnth = da_high_word(MODE64[gnt], gnt ? DVDNTH_P1 : DVDNTH_P0,
                                     gnt ? DVDNTL_P1 : DVDNTL_P0);
    end

    // Control FSM plus operand and result registers; everything waits on CE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= DA_IDLE;
            owner <= 1'b0;
            cnt   <= '0;
            q_r   <= '0;
            r_r   <= '0;
            ovf_r <= 1'b0;
            op_q  <= '0;
        end else if (CE) begin
            unique case (state)
                DA_IDLE: begin
                    if (gnt_valid) begin
                        owner <= gnt;
                        op_q  <= op_sel;
                        state <= DA_LAUNCH;
                    end
                end
                DA_LAUNCH: begin
                    cnt   <= '0;
                    state <= DA_WAIT;
                end
                DA_WAIT: begin
                    if (DIV_DONE) begin
                        q_r   <= DIV_Q;
                        r_r   <= DIV_R;
                        ovf_r <= DIV_OVF;
                        state <= DA_RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        q_r   <= '0;
                        r_r   <= '0;
                        ovf_r <= 1'b1;
                        state <= DA_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DA_RESP: begin
                    state <= DA_IDLE;
                end
                default: begin
                    state <= DA_IDLE;
                end
            endcase
        end
    end

    // Start and ACK are qualified by CE so each lasts exactly one enabled cycle.
    always_comb begin
        ACK = '0;
        if (state == DA_RESP && CE) begin
            ACK[owner] = 1'b1;
        end
        DIV_START = (state == DA_LAUNCH) && CE;
        BUSY      = REQ & ~ACK;
    end

    assign Q          = q_r;
    assign R          = r_r;
    assign OVF        = ovf_r;
    assign DIV_64     = op_q.mode64;
    assign DIV_DVSR   = op_q.dvsr;
    assign DIV_DVDNTH = op_q.dvdnth;
    assign DIV_DVDNTL = op_q.dvdntl;

endmodule

// File: tb/tb_divu_share_arb.sv
// tb_divu_share_arb: vector table plus hand sequences, with a behavioural divide engine
// and an ACK scoreboard.
module tb_divu_share_arb;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CE;
    logic [1:0]  REQ;
    logic [1:0]  MODE64;
    logic [31:0] DVSR_P0, DVSR_P1, DVDNTH_P0, DVDNTH_P1, DVDNTL_P0, DVDNTL_P1;
    logic [1:0]  ACK;
    logic [31:0] Q, R;
    logic        OVF;
    logic [1:0]  BUSY;
    logic        DIV_START, DIV_64;
    logic [31:0] DIV_DVSR, DIV_DVDNTH, DIV_DVDNTL;
    logic        DIV_DONE;
    logic [31:0] DIV_Q, DIV_R;
    logic        DIV_OVF;

    divu_share_arb #(.TIMEOUT(40), .NREQ(2)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .REQ(REQ), .MODE64(MODE64),
        .DVSR_P0(DVSR_P0), .DVSR_P1(DVSR_P1),
        .DVDNTH_P0(DVDNTH_P0), .DVDNTH_P1(DVDNTH_P1),
        .DVDNTL_P0(DVDNTL_P0), .DVDNTL_P1(DVDNTL_P1),
        .ACK(ACK), .Q(Q), .R(R), .OVF(OVF), .BUSY(BUSY),
        .DIV_START(DIV_START), .DIV_64(DIV_64), .DIV_DVSR(DIV_DVSR),
        .DIV_DVDNTH(DIV_DVDNTH), .DIV_DVDNTL(DIV_DVDNTL),
        .DIV_DONE(DIV_DONE), .DIV_Q(DIV_Q), .DIV_R(DIV_R), .DIV_OVF(DIV_OVF)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // ---------------- behavioural divide engine ----------------
    int          eng_delay = 0;
    int          eng_left = 0;
    bit          eng_busy = 0;
    logic        eng_done = 1'b0;
    logic        force_done = 1'b0;
    logic [31:0] eng_q = '0, eng_r = '0;
    logic        eng_ovf = 1'b0;
    logic [63:0] eng_dvd, eng_quo, eng_rem;

    assign DIV_DONE = eng_done | force_done;
    assign DIV_Q    = eng_q;
    assign DIV_R    = eng_r;
    assign DIV_OVF  = eng_ovf;

    always @(negedge CLK) begin
        if (RST) begin
            eng_busy = 0;
            eng_done = 1'b0;
        end else if (CE) begin
            eng_done = 1'b0;
            if (DIV_START) begin
                eng_busy = (eng_delay != 0);
                eng_left = eng_delay;
                eng_dvd  = {DIV_DVDNTH, DIV_DVDNTL};
                if (DIV_DVSR == 32'd0) begin
                    eng_q = 32'hFFFF_FFFF; eng_r = '0; eng_ovf = 1'b1;
                end else begin
                    eng_quo = eng_dvd / {32'd0, DIV_DVSR};
                    eng_rem = eng_dvd % {32'd0, DIV_DVSR};
                    if (eng_quo > 64'h0000_0000_FFFF_FFFF) begin
                        eng_q = 32'hFFFF_FFFF; eng_r = '0; eng_ovf = 1'b1;
                    end else begin
                        eng_q = eng_quo[31:0]; eng_r = eng_rem[31:0]; eng_ovf = 1'b0;
                    end
                end
            end else if (eng_busy) begin
                eng_left--;
                if (eng_left == 0) begin
                    eng_done = 1'b1;
                    eng_busy = 0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [1:0]  ack;
        logic [31:0] q;
        logic [31:0] r;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic push_exp(input logic [1:0] ack, input logic [31:0] q, input logic [31:0] r,
                            input logic ovf);
        exp_t e;
        e.ack = ack; e.q = q; e.r = r; e.ovf = ovf;
        sb.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (!RST && ACK != 2'b00) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {62'd0, ACK}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ack_port", {62'd0, ACK}, {62'd0, mon_e.ack});
                check("ack_q", {32'd0, Q}, {32'd0, mon_e.q});
                check("ack_r", {32'd0, R}, {32'd0, mon_e.r});
                check("ack_ovf", {63'd0, OVF}, {63'd0, mon_e.ovf});
                check("busy_at_ack", {62'd0, BUSY & ACK}, 64'd0);
            end
        end
    end

    // ---------------- engine operand snapshot / stability ----------------
    int          start_cnt = 0;
    int          stab_err = 0;
    bit          op_active = 0;
    logic [31:0] snap_dvsr, snap_hi, snap_lo;
    logic        snap_m64;

    always @(negedge CLK) begin
        if (RST) begin
            op_active = 0;
        end else begin
            if (DIV_START) begin
                start_cnt++;
                snap_dvsr = DIV_DVSR; snap_hi = DIV_DVDNTH; snap_lo = DIV_DVDNTL;
                snap_m64  = DIV_64;
                op_active = 1;
            end else if (op_active) begin
                if (DIV_DVSR !== snap_dvsr || DIV_DVDNTH !== snap_hi ||
                    DIV_DVDNTL !== snap_lo || DIV_64 !== snap_m64) stab_err++;
            end
            if (ACK != 2'b00) op_active = 0;
        end
    end

    // ---------------- helpers ----------------
    bit chk_busy1 = 0;
    int busy1_err = 0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_port(input int p, input logic m64, input logic [31:0] dvsr,
                              input logic [31:0] hi, input logic [31:0] lo);
        if (p == 0) begin
            MODE64[0] = m64; DVSR_P0 = dvsr; DVDNTH_P0 = hi; DVDNTL_P0 = lo;
        end else begin
            MODE64[1] = m64; DVSR_P1 = dvsr; DVDNTH_P1 = hi; DVDNTL_P1 = lo;
        end
    endtask

    task automatic wait_ack(output logic [1:0] a, output int at);
        bit seen;
        seen = 0;
        a    = 2'b00;
        at   = -1;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge CLK);
            if (chk_busy1 && ACK[1] == 1'b0 && BUSY[1] !== 1'b1) busy1_err++;
            if (ACK != 2'b00) begin
                a    = ACK;
                at   = cyc;
                seen = 1;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL ack_wait actual=no_ack required=ack_within_300_cycles");
        end
    endtask

    task automatic wait_start();
        bit seen;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge CLK);
            if (DIV_START) seen = 1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL start_wait actual=no_start required=start_within_50_cycles");
        end
    endtask

    typedef struct {
        int          port;
        logic        m64;
        logic [31:0] dvsr;
        logic [31:0] hi;
        logic [31:0] lo;
        int          delay;   // 0 = engine never completes
        logic [31:0] eq;
        logic [31:0] er;
        logic        eovf;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  a;
        int          at, c0, s0, rem0, rem1, ce_err;
        vec_t        v;
        logic [31:0] exph;

        vecs[0] = '{0, 1'b0, 32'd7,          32'hDEAD_BEEF, 32'd100,         39,
                    32'd14,          32'd2,    1'b0};
        vecs[1] = '{1, 1'b1, 32'd2,          32'd1,         32'd0,           5,
                    32'h8000_0000,   32'd0,    1'b0};
        vecs[2] = '{0, 1'b1, 32'd2,          32'd5,         32'd0,           3,
                    32'hFFFF_FFFF,   32'd0,    1'b1};
        vecs[3] = '{1, 1'b0, 32'd10,         32'h1234_5678, 32'd1000,        1,
                    32'd100,         32'd0,    1'b0};
        vecs[4] = '{0, 1'b0, 32'd3,          32'd0,         32'd9,           0,
                    32'd0,           32'd0,    1'b1};
        vecs[5] = '{1, 1'b0, 32'hFFFF_FFFF,  32'd0,         32'h8000_0010,   4,
                    32'hFFFF_FFFF,   32'd0,    1'b1};
        vecs[6] = '{0, 1'b1, 32'h100,        32'h12,        32'h3456_7890,   10,
                    32'h1234_5678,   32'h90,   1'b0};

        RST = 1'b1; CE = 1'b1; REQ = 2'b00; MODE64 = 2'b00;
        DVSR_P0 = '0; DVSR_P1 = '0; DVDNTH_P0 = '0; DVDNTH_P1 = '0;
        DVDNTL_P0 = '0; DVDNTL_P1 = '0;

        // Reset values.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_ack", {62'd0, ACK}, 64'd0);
        check("rst_qr", {Q, R}, 64'd0);
        check("rst_ovf", {63'd0, OVF}, 64'd0);
        check("rst_start", {63'd0, DIV_START}, 64'd0);
        check("rst_ops", {DIV_DVSR, DIV_DVDNTL}, 64'd0);
        check("rst_dvdnth_64", {31'd0, DIV_64, DIV_DVDNTH}, 64'd0);
        @(posedge CLK); #1 RST = 1'b0;
        step();
        @(negedge CLK);
        check("idle_no_start", {63'd0, DIV_START}, 64'd0);
        step();

        // Simultaneous requests right after reset; port 0 keeps requesting.
        drive_port(0, 1'b0, 32'd7, 32'd0, 32'd100);
        drive_port(1, 1'b0, 32'd5, 32'd0, 32'd50);
        eng_delay = 2;
`ifdef DIVU_ARB_FIXED_PRIO_EN
        push_exp(2'b01, 32'd14, 32'd2, 1'b0);
        push_exp(2'b01, 32'd14, 32'd2, 1'b0);
        push_exp(2'b10, 32'd10, 32'd0, 1'b0);
`else
        push_exp(2'b01, 32'd14, 32'd2, 1'b0);
        push_exp(2'b10, 32'd10, 32'd0, 1'b0);
        push_exp(2'b01, 32'd14, 32'd2, 1'b0);
`endif
        REQ = 2'b11; chk_busy1 = 1; rem0 = 2; rem1 = 1;
        for (int k = 0; k < 3; k++) begin
            wait_ack(a, at);
            if (a[1]) chk_busy1 = 0;
            step();
            if (a[0]) begin rem0--; if (rem0 == 0) REQ[0] = 1'b0; end
            if (a[1]) begin rem1--; if (rem1 == 0) REQ[1] = 1'b0; end
        end
        chk_busy1 = 0;
        REQ = 2'b00;
        check("busy1_held_until_ack", busy1_err, 0);
        check("tie_all_served", sb.size(), 0);
        step();

        // Vector table: one request at a time.
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            exph = v.m64 ? v.hi : {32{v.lo[31]}};
            drive_port(v.port, v.m64, v.dvsr, v.hi, v.lo);
            eng_delay = v.delay;
            push_exp(v.port == 1 ? 2'b10 : 2'b01, v.eq, v.er, v.eovf);
            s0 = start_cnt; c0 = cyc;
            REQ[v.port] = 1'b1;
            wait_ack(a, at);
            check("latency", at - c0, (v.delay == 0) ? 42 : 2 + v.delay);
            check("start_pulses", start_cnt - s0, 1);
            check("op_dvsr", {32'd0, snap_dvsr}, {32'd0, v.dvsr});
            check("op_dvdnth", {32'd0, snap_hi}, {32'd0, exph});
            check("op_dvdntl", {32'd0, snap_lo}, {32'd0, v.lo});
            check("op_mode64", {63'd0, snap_m64}, {63'd0, v.m64});
            step();
            REQ[v.port] = 1'b0;
            @(negedge CLK);
            check("hold_qr", {Q, R}, {v.eq, v.er});
            check("hold_ovf_noack", {61'd0, ACK, OVF}, {61'd0, 2'b00, v.eovf});
            step();
        end

        // Reset in WAIT, then a late DONE.
        drive_port(0, 1'b1, 32'd3, 32'h77, 32'h1234);
        eng_delay = 0;
        REQ[0] = 1'b1;
        wait_start();
        repeat (10) step();
        REQ = 2'b00;
        RST = 1'b1;
        @(negedge CLK);
        check("rstmid_ack_busy", {60'd0, ACK, BUSY}, 64'd0);
        check("rstmid_qr", {Q, R}, 64'd0);
        check("rstmid_ovf_start", {62'd0, OVF, DIV_START}, 64'd0);
        check("rstmid_ops", {DIV_DVSR, DIV_DVDNTH}, 64'd0);
        check("rstmid_lo_64", {31'd0, DIV_64, DIV_DVDNTL}, 64'd0);
        step();
        RST = 1'b0;
        force_done = 1'b1;
        step(); step();
        force_done = 1'b0;
        repeat (3) step();
        @(negedge CLK);
        check("late_done_ignored", {29'd0, ACK, OVF, Q}, 64'd0);
        step();
        drive_port(1, 1'b0, 32'd10, 32'd0, 32'd1000);
        eng_delay = 3;
        push_exp(2'b10, 32'd100, 32'd0, 1'b0);
        c0 = cyc;
        REQ[1] = 1'b1;
        wait_ack(a, at);
        check("post_rst_latency", at - c0, 5);
        step();
        REQ[1] = 1'b0;
        step();

        // DONE during LAUNCH, CE low for 5 cycles in WAIT, port 1 withdraws.
        drive_port(0, 1'b0, 32'd7, 32'd0, 32'd100);
        eng_delay = 0;
        push_exp(2'b01, 32'd0, 32'd0, 1'b1);
        c0 = cyc;
        REQ[0] = 1'b1;
        wait_start();
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        REQ[1] = 1'b1;
        step();
        CE = 1'b0;
        ce_err = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (ACK !== 2'b00 || DIV_START !== 1'b0) ce_err++;
            @(posedge CLK);
        end
        #1 CE = 1'b1;
        REQ[1] = 1'b0;
        wait_ack(a, at);
        check("ce_freeze_latency", at - c0, 47);
        check("ce_low_quiet", ce_err, 0);
        step();
        REQ[0] = 1'b0;
        repeat (4) step();

        check("scoreboard_empty", sb.size(), 0);
        check("operands_stable", stab_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
